// File: rtl/saa_ctrl.sv
// saa_ctrl: owns the single write port of the SAA1099 sound core.
// Merges buffered Z80 port writes (CPU FIFO) with atomic register writes
// from the music sequencer, runs a generator-reset sequence after reset and
// produces cs_n/wr_n/a0/din bus cycles paced by the 8 MHz clock enable.
//
// Ports:
//   clk_sys, rst            system clock, asynchronous active-high reset
//   ce                      8 MHz clock enable (bus-cycle pacing)
//   cpu_wr/cpu_a0/cpu_d     CPU port write strobe, port select, data
//   cpu_full, cpu_ovf       FIFO full flag, sticky overflow flag
//   seq_req/seq_reg/seq_val sequencer register-write request
//   seq_ack                 one-clock completion pulse for a sequencer pair
//   init_done               initialisation sequence finished
//   saa_cs_n/wr_n/a0/d      registered bus to the saa1099 instance
module saa_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       ce,
    input  logic       cpu_wr,
    input  logic       cpu_a0,
    input  logic [7:0] cpu_d,
    output logic       cpu_full,
    output logic       cpu_ovf,
    input  logic       seq_req,
    input  logic [4:0] seq_reg,
    input  logic [7:0] seq_val,
    output logic       seq_ack,
    output logic       init_done,
    output logic       saa_cs_n,
    output logic       saa_wr_n,
    output logic       saa_a0,
    output logic [7:0] saa_d
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_STROBE1, ST_STROBE2, ST_HOLD
    } bus_state_t;

    // Which kind of bus cycle is in flight; chained kinds follow on directly.
    typedef enum logic [2:0] {
        K_INIT0A, K_INIT0D, K_INIT1A, K_INIT1D,
        K_CPU, K_SEQ_ADDR, K_SEQ_DATA, K_RESTORE
    } kind_t;

    // CPU FIFO storage: each entry is {a0, d}
    logic [8:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_nxt_s;
    logic          fifo_full_s, fifo_empty_s, push_s, pop_s;
    logic          head_a0_s;
    logic [7:0]    head_d_s;

    bus_state_t state_r, state_nxt_s;
    kind_t      kind_r, kind_nxt_s;
    logic       cs_nxt_s, wr_nxt_s, a0_nxt_s, ack_nxt_s, init_nxt_s;
    logic [7:0] d_nxt_s;
    logic [7:0] pend_r, pend_nxt_s;     // second half of a chained pair
    logic [7:0] shadow_r, shadow_nxt_s; // last CPU-selected register address
    logic       dirty_r, dirty_nxt_s;   // chip address latch may differ from shadow
    logic       last_seq_r, last_seq_nxt_s;

    logic       seq_ok_s, serve_cpu_s, serve_seq_s;
    logic       launch_s, launch_a0_s;
    kind_t      launch_kind_s;
    logic [7:0] launch_d_s;

    assign fifo_full_s  = (count_r == DEPTH_C);
    assign fifo_empty_s = (count_r == {CW{1'b0}});
    assign head_a0_s    = fifo_mem_r[rd_ptr_r][8];
    assign head_d_s     = fifo_mem_r[rd_ptr_r][7:0];
    // A full FIFO still accepts a write when the head leaves in the same clock
    assign push_s       = cpu_wr && (!fifo_full_s || pop_s);

    // Arbitration: CPU first after a SEQ pair; a request is never re-served in its ack clock
    always_comb begin
        seq_ok_s    = seq_req && !seq_ack;
        serve_cpu_s = init_done && !fifo_empty_s && (last_seq_r || !seq_ok_s);
        serve_seq_s = init_done && !serve_cpu_s && seq_ok_s;
    end

    // Selects the next bus cycle: chained follow-on from HOLD, or a fresh start from IDLE
    always_comb begin
        launch_s      = 1'b0;
        launch_kind_s = K_CPU;
        launch_a0_s   = 1'b0;
        launch_d_s    = 8'h00;
        if (state_r == ST_HOLD) begin
            case (kind_r)
                K_INIT0A:   begin launch_s = 1'b1; launch_kind_s = K_INIT0D;   launch_a0_s = 1'b0; launch_d_s = 8'h02;  end
                K_INIT0D:   begin launch_s = 1'b1; launch_kind_s = K_INIT1A;   launch_a0_s = 1'b1; launch_d_s = 8'h1C;  end
                K_INIT1A:   begin launch_s = 1'b1; launch_kind_s = K_INIT1D;   launch_a0_s = 1'b0; launch_d_s = 8'h00;  end
                K_SEQ_ADDR: begin launch_s = 1'b1; launch_kind_s = K_SEQ_DATA; launch_a0_s = 1'b0; launch_d_s = pend_r; end
                K_RESTORE:  begin launch_s = 1'b1; launch_kind_s = K_CPU;      launch_a0_s = 1'b0; launch_d_s = pend_r; end
                default:    begin launch_s = 1'b0; end
            endcase
        end else if (state_r == ST_IDLE) begin
            if (!init_done) begin
                launch_s = 1'b1; launch_kind_s = K_INIT0A; launch_a0_s = 1'b1; launch_d_s = 8'h1C;
            end else if (serve_cpu_s) begin
                launch_s = 1'b1;
                if (!head_a0_s && dirty_r) begin
                    launch_kind_s = K_RESTORE; launch_a0_s = 1'b1; launch_d_s = shadow_r;
                end else begin
                    launch_kind_s = K_CPU; launch_a0_s = head_a0_s; launch_d_s = head_d_s;
                end
            end else if (serve_seq_s) begin
                launch_s = 1'b1; launch_kind_s = K_SEQ_ADDR; launch_a0_s = 1'b1;
                launch_d_s = {3'b000, seq_reg};
            end else begin
                launch_s = 1'b0;
            end
        end else begin
            launch_s = 1'b0;
        end
    end

    // Bus-cycle FSM next state and next values of all registered outputs
    always_comb begin
        state_nxt_s    = state_r;
        kind_nxt_s     = kind_r;
        cs_nxt_s       = saa_cs_n;
        wr_nxt_s       = saa_wr_n;
        a0_nxt_s       = saa_a0;
        d_nxt_s        = saa_d;
        ack_nxt_s      = 1'b0;
        init_nxt_s     = init_done;
        pend_nxt_s     = pend_r;
        shadow_nxt_s   = shadow_r;
        dirty_nxt_s    = dirty_r;
        last_seq_nxt_s = last_seq_r;
        pop_s          = 1'b0;
        if (ce) begin
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        state_nxt_s = ST_SETUP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SETUP:   begin state_nxt_s = ST_STROBE1; wr_nxt_s = 1'b0; end
                ST_STROBE1: begin state_nxt_s = ST_STROBE2; end
                ST_STROBE2: begin state_nxt_s = ST_HOLD;    wr_nxt_s = 1'b1; end
                ST_HOLD: begin
                    if (launch_s) begin
                        state_nxt_s = ST_SETUP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        cs_nxt_s    = 1'b1;
                        if (kind_r == K_SEQ_DATA) begin
                            ack_nxt_s      = 1'b1;
                            last_seq_nxt_s = 1'b1;
                        end else if (kind_r == K_INIT1D) begin
                            init_nxt_s  = 1'b1;
                            dirty_nxt_s = 1'b1;
                        end else begin
                            ack_nxt_s = 1'b0;
                        end
                    end
                end
                default: begin state_nxt_s = ST_IDLE; cs_nxt_s = 1'b1; wr_nxt_s = 1'b1; end
            endcase
            if (launch_s) begin
                kind_nxt_s = launch_kind_s;
                cs_nxt_s   = 1'b0;
                wr_nxt_s   = 1'b1;
                a0_nxt_s   = launch_a0_s;
                d_nxt_s    = launch_d_s;
                pop_s      = (state_r == ST_IDLE) && serve_cpu_s;
                case (launch_kind_s)
                    K_CPU: begin
                        last_seq_nxt_s = 1'b0;
                        if (launch_a0_s) begin
                            shadow_nxt_s = launch_d_s;
                            dirty_nxt_s  = 1'b0;
                        end else begin
                            shadow_nxt_s = shadow_r;
                        end
                    end
                    K_RESTORE:  begin dirty_nxt_s = 1'b0; pend_nxt_s = head_d_s; end
                    K_SEQ_ADDR: begin dirty_nxt_s = 1'b1; pend_nxt_s = seq_val;  end
                    default:    begin pend_nxt_s = pend_r; end
                endcase
            end else begin
                kind_nxt_s = kind_r;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FIFO occupancy after this clock's push/pop
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
    end

    // Bus FSM, outputs and shadow/arbitration state registers
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            kind_r     <= K_INIT0A;
            saa_cs_n   <= 1'b1;
            saa_wr_n   <= 1'b1;
            saa_a0     <= 1'b0;
            saa_d      <= 8'h00;
            seq_ack    <= 1'b0;
            init_done  <= 1'b0;
            pend_r     <= 8'h00;
            shadow_r   <= 8'h00;
            dirty_r    <= 1'b0;
            last_seq_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            kind_r     <= kind_nxt_s;
            saa_cs_n   <= cs_nxt_s;
            saa_wr_n   <= wr_nxt_s;
            saa_a0     <= a0_nxt_s;
            saa_d      <= d_nxt_s;
            seq_ack    <= ack_nxt_s;
            init_done  <= init_nxt_s;
            pend_r     <= pend_nxt_s;
            shadow_r   <= shadow_nxt_s;
            dirty_r    <= dirty_nxt_s;
            last_seq_r <= last_seq_nxt_s;
        end
    end

    // FIFO pointers, count and status flags
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            cpu_full <= 1'b0;
            cpu_ovf  <= 1'b0;
        end else begin
            wr_ptr_r <= push_s ? wr_ptr_r + {{(PW-1){1'b0}}, 1'b1} : wr_ptr_r;
            rd_ptr_r <= pop_s  ? rd_ptr_r + {{(PW-1){1'b0}}, 1'b1} : rd_ptr_r;
            count_r  <= count_nxt_s;
            cpu_full <= (count_nxt_s == DEPTH_C);
            cpu_ovf  <= cpu_ovf || (cpu_wr && !push_s);
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk_sys) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {cpu_a0, cpu_d};
        end
    end
endmodule

// File: tb/tb_saa_ctrl.sv
module tb_saa_ctrl;
    logic       clk_sys = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic       cpu_wr = 1'b0;
    logic       cpu_a0 = 1'b0;
    logic [7:0] cpu_d = 8'h00;
    logic       cpu_full, cpu_ovf;
    logic       seq_req = 1'b0;
    logic [4:0] seq_reg = 5'h00;
    logic [7:0] seq_val = 8'h00;
    logic       seq_ack, init_done;
    logic       saa_cs_n, saa_wr_n, saa_a0;
    logic [7:0] saa_d;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];
    logic       ce_en = 1'b1;
    int         div = 0;
    logic       prev_wr = 1'b1;
    logic       prev_ack = 1'b0;
    int         low_ticks = 0;
    logic [8:0] cap = 9'h000;

    saa_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk_sys(clk_sys), .rst(rst), .ce(ce),
        .cpu_wr(cpu_wr), .cpu_a0(cpu_a0), .cpu_d(cpu_d),
        .cpu_full(cpu_full), .cpu_ovf(cpu_ovf),
        .seq_req(seq_req), .seq_reg(seq_reg), .seq_val(seq_val), .seq_ack(seq_ack),
        .init_done(init_done),
        .saa_cs_n(saa_cs_n), .saa_wr_n(saa_wr_n), .saa_a0(saa_a0), .saa_d(saa_d)
    );

    always #5 clk_sys = ~clk_sys;

    // ce every 4th clock while enabled
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            div = div + 1;
            ce = ce_en && (div % 4 == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Bus monitor: compares each strobed cycle against the scoreboard
    always @(negedge clk_sys) begin
        if (prev_wr === 1'b1 && saa_wr_n === 1'b0) begin
            cap = {saa_a0, saa_d};
            low_ticks = 0;
            check("bus_cs_low", {31'd0, saa_cs_n}, 32'd0);
            if (exp_q.size() == 0) begin
                check("bus_extra_cycle", exp_q.size(), 1);
            end else begin
                check("bus_cycle", {23'd0, cap}, {23'd0, exp_q.pop_front()});
            end
        end
        if (saa_wr_n === 1'b0 && ce === 1'b1) low_ticks++;
        if (prev_wr === 1'b0 && saa_wr_n === 1'b1 && !rst) begin
            check("strobe_ticks", low_ticks, 2);
            check("bus_hold", {23'd0, saa_a0, saa_d}, {23'd0, cap});
        end
        if (prev_ack) check("ack_width", {31'd0, seq_ack}, 32'd0);
        if (seq_ack && !prev_ack) check("ack_after_data", {23'd0, cap}, {23'd0, 1'b0, seq_val});
        prev_wr = saa_wr_n;
        prev_ack = seq_ack;
    end

    task automatic cpu_push(input logic a0, input logic [7:0] d);
        cpu_wr = 1'b1; cpu_a0 = a0; cpu_d = d;
        @(negedge clk_sys);
        cpu_wr = 1'b0;
    endtask

    task automatic push_init();
        exp_q.push_back({1'b1, 8'h1C}); exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b1, 8'h1C}); exp_q.push_back({1'b0, 8'h00});
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || saa_cs_n !== 1'b1) && n < 3000) begin
            @(negedge clk_sys); n++;
        end
        check(tag, {31'd0, (n < 3000)}, 32'd1);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (init_done !== 1'b1 && n < 500) begin
            @(negedge clk_sys); n++;
        end
        check(tag, {31'd0, init_done}, 32'd1);
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (seq_ack !== 1'b1 && n < 1000) begin
            @(negedge clk_sys); n++;
        end
        check(tag, {31'd0, seq_ack}, 32'd1);
        @(negedge clk_sys);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk_sys);
        check("rst_cs_n", {31'd0, saa_cs_n}, 32'd1);
        check("rst_wr_n", {31'd0, saa_wr_n}, 32'd1);
        check("rst_a0_d", {23'd0, saa_a0, saa_d}, 32'd0);
        check("rst_flags", {27'd0, cpu_full, cpu_ovf, seq_ack, init_done, 1'b0}, 32'd0);

        // Initialisation sequence
        push_init();
        rst = 1'b0;
        wait_init("init_done");
        wait_drain("init_drain");

        // CPU address then data, no restore; check launch latency
        exp_q.push_back({1'b1, 8'h08}); exp_q.push_back({1'b0, 8'h55});
        cpu_push(1'b1, 8'h08);
        begin
            int n = 0;
            while (ce !== 1'b1 && n < 20) begin @(negedge clk_sys); n++; end
        end
        check("lat_cs_before", {31'd0, saa_cs_n}, 32'd1);
        @(negedge clk_sys);
        check("lat_cs_fall", {31'd0, saa_cs_n}, 32'd0);
        cpu_push(1'b0, 8'h55);
        wait_drain("cpu_pair_drain");

        // SEQ pair interleaved with CPU data: restore of shadow 0x08
        exp_q.push_back({1'b1, 8'h14}); exp_q.push_back({1'b0, 8'h3F});
        exp_q.push_back({1'b1, 8'h08}); exp_q.push_back({1'b0, 8'h77});
        seq_req = 1'b1; seq_reg = 5'h14; seq_val = 8'h3F;
        cpu_push(1'b0, 8'h77);
        wait_ack("seq_ack_seen");
        seq_req = 1'b0;
        wait_drain("restore_drain");

        // Stall and overflow
        ce_en = 1'b0;
        repeat (2) @(negedge clk_sys);
        exp_q.push_back({1'b1, 8'h10}); exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h12}); exp_q.push_back({1'b1, 8'h13});
        cpu_push(1'b1, 8'h10); cpu_push(1'b0, 8'h11);
        cpu_push(1'b0, 8'h12); cpu_push(1'b1, 8'h13);
        check("full_set", {31'd0, cpu_full}, 32'd1);
        check("ovf_clear", {31'd0, cpu_ovf}, 32'd0);
        cpu_push(1'b0, 8'h99);
        check("ovf_set", {31'd0, cpu_ovf}, 32'd1);
        check("full_hold", {31'd0, cpu_full}, 32'd1);
        ce_en = 1'b1;
        wait_drain("stall_drain");
        check("full_clear", {31'd0, cpu_full}, 32'd0);

        // Held request alternates with CPU entries
        ce_en = 1'b0;
        repeat (2) @(negedge clk_sys);
        cpu_push(1'b1, 8'h21); cpu_push(1'b1, 8'h22);
        seq_req = 1'b1; seq_reg = 5'h05; seq_val = 8'hA5;
        exp_q.push_back({1'b1, 8'h05}); exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b1, 8'h21});
        exp_q.push_back({1'b1, 8'h05}); exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b1, 8'h22});
        ce_en = 1'b1;
        wait_ack("alt_ack1");
        wait_ack("alt_ack2");
        seq_req = 1'b0;
        wait_drain("alt_drain");

        // Reset during STROBE1
        exp_q.push_back({1'b1, 8'h30});
        cpu_push(1'b1, 8'h30); cpu_push(1'b0, 8'h31);
        begin
            int n = 0;
            while (saa_wr_n !== 1'b0 && n < 100) begin @(negedge clk_sys); n++; end
        end
        check("strobe_reached", {31'd0, saa_wr_n}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_wr_n", {31'd0, saa_wr_n}, 32'd1);
        check("mid_rst_cs_n", {31'd0, saa_cs_n}, 32'd1);
        check("mid_rst_flags", {29'd0, cpu_ovf, init_done, cpu_full}, 32'd0);
        push_init();
        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        wait_init("reinit_done");
        wait_drain("reinit_drain");
        repeat (60) @(negedge clk_sys);
        check("fifo_empty_after_rst", exp_q.size(), 0);
        check("idle_after_rst", {31'd0, saa_cs_n}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
